// File: rtl/noc_flit_tx.sv
// Packet injector for one mesh router local port: a header flit carrying the
// destination, then PACKET_LEN payload flits drawn from a small payload FIFO.
module noc_flit_tx #(
   parameter int BUS_SIZE   = 4,
   parameter int ADDR_SIZE  = 4,
   parameter int PACKET_LEN = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8
) (
   input  logic                 clk_i,
   input  logic                 a_rst_n_i,
   input  logic                 pkt_valid_i,
   input  logic [ADDR_SIZE-1:0] pkt_dest_i,
   output logic                 pkt_ready_o,
   input  logic [BUS_SIZE-1:0]  host_data_i,
   input  logic                 host_w_i,
   output logic                 host_r_o,
   output logic [BUS_SIZE-1:0]  data_o,
   output logic                 w_o,
   input  logic                 r_i,
   output logic                 busy_o,
   output logic [CNT_W-1:0]     sent_cnt_o,
   output logic [1:0]           dbg_state_o
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FLIT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

   // Handshake: a flit moves on w_o && r_i, a payload push on host_w_i && host_r_o,
   // a request is taken on pkt_valid_i && pkt_ready_o; once raised, w_o/data_o hold until r_i.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HEAD = 2'd1,
      S_BODY = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [BUS_SIZE-1:0]   r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W:0]        r_count;
   logic [PTR_W:0]        w_count_nxt;
   logic [FLIT_W-1:0]     r_flit_cnt;
   logic [ADDR_SIZE-1:0]  r_dest;
   logic [CNT_W-1:0]      r_sent_cnt;
   logic                  r_pkt_ready;
   logic                  r_host_r;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_empty;
   logic                  w_last;
   logic                  w_accept;
   logic                  w_flit_valid;
   logic [BUS_SIZE-1:0]   w_flit_data;
   logic                  w_done;

   // A full FIFO rejects pushes even when a pop happens in the same cycle.
   assign w_empty  = (r_count == '0);
   assign w_push   = host_w_i && r_host_r;
   assign w_pop    = (r_state == S_BODY) && !w_empty && r_i;
   assign w_last   = (r_flit_cnt == FLIT_W'(PACKET_LEN - 1));
   assign w_accept = (r_state == S_IDLE) && pkt_valid_i && r_pkt_ready;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_flit_valid = 1'b0;
      w_flit_data  = '0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_HEAD;
         end
         S_HEAD: begin
            w_flit_valid = 1'b1;
            w_flit_data  = BUS_SIZE'(r_dest);
            if (r_i) w_state_nxt = S_BODY;
         end
         S_BODY: begin
            w_flit_valid = !w_empty;
            w_flit_data  = w_empty ? '0 : r_mem[r_rd_ptr];
            if (w_pop && w_last) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         r_state     <= S_IDLE;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_flit_cnt  <= '0;
         r_dest      <= '0;
         r_sent_cnt  <= '0;
         r_pkt_ready <= 1'b0;
         r_host_r    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         r_pkt_ready <= (w_state_nxt == S_IDLE);
         r_host_r    <= (w_count_nxt != (PTR_W+1)'(FIFO_DEPTH));
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_accept) r_dest <= pkt_dest_i;
         if (r_state == S_HEAD && r_i) r_flit_cnt <= '0;
         else if (w_pop)               r_flit_cnt <= r_flit_cnt + 1'b1;
         if (w_done) r_sent_cnt <= r_sent_cnt + 1'b1;
      end
   end

   // Payload storage needs no reset: it is only read while the count says it is valid.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= host_data_i;
   end

   assign pkt_ready_o = r_pkt_ready;
   assign host_r_o    = r_host_r;
   assign w_o         = w_flit_valid;
   assign data_o      = w_flit_data;
   assign busy_o      = (r_state != S_IDLE);
   assign sent_cnt_o  = r_sent_cnt;
   assign dbg_state_o = r_state;

endmodule
